// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the gshare branch predictor.
// Holds the 2-bit saturating counter encoding, the counter reset value and
// the saturating counter update used by the pattern history table.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,  // strongly not-taken
    BP_WNT = 2'b01,  // weakly not-taken
    BP_WT  = 2'b10,  // weakly taken
    BP_ST  = 2'b11   // strongly taken
  } bp_ctr_e;

  localparam bp_ctr_e BP_INIT = BP_WNT;

  // Saturating step: moves one state toward the resolved direction,
  // sticking at BP_SNT / BP_ST.
  function automatic bp_ctr_e bp_ctr_next(input bp_ctr_e ctr, input logic taken);
    bp_ctr_e nxt;
    nxt = ctr;
    case (ctr)
      BP_SNT:  nxt = taken ? BP_WNT : BP_SNT;
      BP_WNT:  nxt = taken ? BP_WT  : BP_SNT;
      BP_WT:   nxt = taken ? BP_ST  : BP_WNT;
      BP_ST:   nxt = taken ? BP_ST  : BP_WT;
      default: nxt = BP_INIT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2^INDEX_W two-bit saturating counters.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset, all counters to BP_INIT
//   rd_idx_i   - asynchronous read index
//   rd_taken_o - MSB of the addressed counter (predict taken)
//   wr_en_i    - apply one saturating update at this edge
//   wr_idx_i   - counter to update
//   wr_taken_i - resolved direction: increment if 1, decrement if 0
module bp_pht
  import branch_predictor_pkg::*;
#(
  parameter int unsigned INDEX_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_taken_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic               wr_taken_i
);

  localparam int unsigned DEPTH = 1 << INDEX_W;

  bp_ctr_e    pht_q [DEPTH];
  logic [1:0] rd_ctr;

  // Read is combinational from the registered array, so a same-edge write
  // is never visible to the current read (read-before-write).
  assign rd_ctr     = pht_q[rd_idx_i];
  assign rd_taken_o = rd_ctr[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pht_q[i] <= BP_INIT;
      end
    end else if (wr_en_i) begin
      pht_q[wr_idx_i] <= bp_ctr_next(pht_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor.
// Predicts conditional branches in Decode, carries the prediction and its
// table index to Execute, trains the PHT with the resolved outcome and
// repairs the speculative global history on a mispredict.
// Ports:
//   clk, resetn             - clock and asynchronous active-low reset
//   pc_D, branch_D, stall_D - Decode instruction PC / is-branch / hold
//   stall_E, flush_E        - Execute hold / clear
//   actual_take_E           - resolved direction of the Execute branch
//   pred_take_D             - prediction for the Decode instruction
//   pred_take_E             - prediction held in Execute
//   branch_valid_E          - Execute holds a predicted conditional branch
//   mispredict_E            - Execute branch resolved against its prediction
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned GHR_W   = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc_D,
  input  logic        branch_D,
  input  logic        stall_D,
  input  logic        stall_E,
  input  logic        flush_E,
  input  logic        actual_take_E,
  output logic        pred_take_D,
  output logic        pred_take_E,
  output logic        branch_valid_E,
  output logic        mispredict_E
);

  logic [GHR_W-1:0]   ghr_q, ghr_d;
  logic               valid_e_q, valid_e_d;
  logic [INDEX_W-1:0] idx_e_q, idx_e_d;
  logic [GHR_W-1:0]   snap_e_q, snap_e_d;
  logic               pred_e_q, pred_e_d;
  logic [INDEX_W-1:0] idx_d;
  logic               pht_taken;
  logic               train;
  // One bit wider than the history so the shift also works for GHR_W = 1.
  logic [GHR_W:0]     spec_hist, repair_hist;
  logic               unused_pc_bits;

  assign unused_pc_bits = ^{pc_D[31:INDEX_W+2], pc_D[1:0]};

  assign idx_d = pc_D[INDEX_W+1:2] ^ INDEX_W'(ghr_q);

  bp_pht #(
    .INDEX_W (INDEX_W)
  ) u_pht (
    .clk        (clk),
    .rst_n      (resetn),
    .rd_idx_i   (idx_d),
    .rd_taken_o (pht_taken),
    .wr_en_i    (train),
    .wr_idx_i   (idx_e_q),
    .wr_taken_i (actual_take_E)
  );

  assign pred_take_D    = branch_D & pht_taken;
  assign pred_take_E    = pred_e_q;
  assign branch_valid_E = valid_e_q;
  assign mispredict_E   = valid_e_q & (actual_take_E != pred_e_q);

  // Train exactly once: on the first edge the E branch is not held.
  assign train = valid_e_q & ~stall_E;

  assign spec_hist   = {ghr_q, pred_take_D};
  assign repair_hist = {snap_e_q, actual_take_E};

  always_comb begin
    ghr_d = ghr_q;
    // Repair wins: the Decode instruction is on the wrong path.
    if (train && mispredict_E) begin
      ghr_d = repair_hist[GHR_W-1:0];
    end else if (branch_D && !stall_D) begin
      ghr_d = spec_hist[GHR_W-1:0];
    end
  end

  always_comb begin
    valid_e_d = valid_e_q;
    idx_e_d   = idx_e_q;
    snap_e_d  = snap_e_q;
    pred_e_d  = pred_e_q;
    if (flush_E) begin
      valid_e_d = 1'b0;
    end else if (!stall_E) begin
      valid_e_d = branch_D & ~stall_D;
      idx_e_d   = idx_d;
      snap_e_d  = ghr_q;
      pred_e_d  = pred_take_D;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ghr_q     <= '0;
      valid_e_q <= 1'b0;
      idx_e_q   <= '0;
      snap_e_q  <= '0;
      pred_e_q  <= 1'b0;
    end else begin
      ghr_q     <= ghr_d;
      valid_e_q <= valid_e_d;
      idx_e_q   <= idx_e_d;
      snap_e_q  <= snap_e_d;
      pred_e_q  <= pred_e_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized run against an integer-level model of the gshare rules.
module tb_branch_predictor;

  localparam int unsigned IW   = 10;
  localparam int unsigned GW   = 8;
  localparam int          NENT = 1 << IW;
  localparam int          GMSK = (1 << GW) - 1;

  logic        clk;
  logic        resetn;
  logic [31:0] pc_D;
  logic        branch_D, stall_D, stall_E, flush_E, actual_take_E;
  logic        pred_take_D, pred_take_E, branch_valid_E, mispredict_E;

  branch_predictor #(.INDEX_W(IW), .GHR_W(GW)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .pc_D           (pc_D),
    .branch_D       (branch_D),
    .stall_D        (stall_D),
    .stall_E        (stall_E),
    .flush_E        (flush_E),
    .actual_take_E  (actual_take_E),
    .pred_take_D    (pred_take_D),
    .pred_take_E    (pred_take_E),
    .branch_valid_E (branch_valid_E),
    .mispredict_E   (mispredict_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers).
  int m_pht [NENT];
  int m_ghr;
  bit m_vE, m_pE;
  int m_idxE, m_snap;

  function automatic int cur_idx();
    return int'((pc_D >> 2) & 32'(NENT - 1)) ^ m_ghr;
  endfunction

  function automatic bit exp_predD();
    return (branch_D === 1'b1) && (m_pht[cur_idx()] >= 2);
  endfunction

  function automatic bit exp_mis();
    return m_vE && (actual_take_E !== m_pE);
  endfunction

  // PC whose table index lands on idx under the current model history;
  // bits outside the index field are randomized and must be ignored.
  function automatic logic [31:0] pc_for(input int idx);
    logic [31:0] junk;
    junk = $urandom & 32'hFFFF_F003;
    return junk | 32'((idx ^ m_ghr) << 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) m_pht[i] = 1;
    m_ghr = 0; m_vE = 0; m_pE = 0; m_idxE = 0; m_snap = 0;
  endtask

  task automatic model_edge();
    int idx     = cur_idx();
    bit pd      = exp_predD();
    bit mis     = exp_mis();
    int old_ghr = m_ghr;
    bit trn     = m_vE && (stall_E !== 1'b1);
    if (trn) begin
      if (actual_take_E === 1'b1) m_pht[m_idxE] = (m_pht[m_idxE] == 3) ? 3 : m_pht[m_idxE] + 1;
      else                        m_pht[m_idxE] = (m_pht[m_idxE] == 0) ? 0 : m_pht[m_idxE] - 1;
    end
    if (trn && mis)
      m_ghr = ((m_snap << 1) | int'(actual_take_E)) & GMSK;
    else if (branch_D === 1'b1 && stall_D !== 1'b1)
      m_ghr = ((old_ghr << 1) | int'(pd)) & GMSK;
    if (flush_E === 1'b1) begin
      m_vE = 0;
    end else if (stall_E !== 1'b1) begin
      m_vE   = (branch_D === 1'b1) && (stall_D !== 1'b1);
      m_idxE = idx;
      m_snap = old_ghr;
      m_pE   = pd;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    pc_D = '0; branch_D = 0; stall_D = 0; stall_E = 0; flush_E = 0; actual_take_E = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    resetn = 0;
    model_reset();
    @(negedge clk);
    resetn = 1;
    tick();
  endtask

  task automatic issue_resolve(input logic [31:0] pc, input bit act);
    pc_D = pc; branch_D = 1; #1;
    tick();
    branch_D = 0; actual_take_E = act; #1;
    tick();
    actual_take_E = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (pred_take_E !== 1'b0) begin errors++; $display("FAIL reset_pred_E got %0b expected 0", pred_take_E); end
    checks++; if (branch_valid_E !== 1'b0) begin errors++; $display("FAIL reset_valid_E got %0b expected 0", branch_valid_E); end
    checks++; if (mispredict_E !== 1'b0) begin errors++; $display("FAIL reset_mispredict got %0b expected 0", mispredict_E); end
    pc_D = 32'h0040_0010; branch_D = 1; #1;
    checks++; if (pred_take_D !== 1'b0) begin errors++; $display("FAIL first_pred_D got %0b expected 0", pred_take_D); end
    tick();
    branch_D = 0; actual_take_E = 1; #1;
    checks++; if (branch_valid_E !== 1'b1) begin errors++; $display("FAIL first_valid_E got %0b expected 1", branch_valid_E); end
    checks++; if (pred_take_E !== 1'b0) begin errors++; $display("FAIL first_pred_E got %0b expected 0", pred_take_E); end
    checks++; if (mispredict_E !== 1'b1) begin errors++; $display("FAIL first_mispredict got %0b expected 1", mispredict_E); end
    tick();
    // ghr is now 1 and pht[4] is weakly taken: index 5 ^ 1 hits entry 4.
    actual_take_E = 0; pc_D = 32'h0040_0014; branch_D = 1; #1;
    checks++; if (pred_take_D !== 1'b1) begin errors++; $display("FAIL first_trained_pred got %0b expected 1", pred_take_D); end
    set_idle();
  endtask

  task automatic test_saturation();
    bit exp_p [5] = '{0, 1, 1, 1, 1};
    bit acts  [4] = '{1, 1, 1, 0};
    bit exp_m [4] = '{1, 0, 0, 1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      pc_D = pc_for(32'h0C3); branch_D = 1; #1;
      checks++; if (pred_take_D !== exp_p[k]) begin errors++; $display("FAIL sat_pred[%0d] got %0b expected %0b", k, pred_take_D, exp_p[k]); end
      if (k < 4) begin
        tick();
        branch_D = 0; actual_take_E = acts[k]; #1;
        checks++; if (mispredict_E !== exp_m[k]) begin errors++; $display("FAIL sat_mis[%0d] got %0b expected %0b", k, mispredict_E, exp_m[k]); end
        tick();
      end
    end
    set_idle();
  endtask

  task automatic test_stall_e();
    do_reset();
    pc_D = pc_for(7); branch_D = 1; #1;
    tick();
    branch_D = 0; actual_take_E = 1; stall_E = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (mispredict_E !== 1'b1) begin errors++; $display("FAIL stall_mis[%0d] got %0b expected 1", k, mispredict_E); end
      tick();
    end
    stall_E = 0; #1;
    tick();
    actual_take_E = 0;
    pc_D = pc_for(7); branch_D = 1; #1;
    checks++; if (pred_take_D !== 1'b1) begin errors++; $display("FAIL stall_once_pred got %0b expected 1", pred_take_D); end
    tick();
    branch_D = 0; actual_take_E = 0; #1;
    tick();
    pc_D = pc_for(7); branch_D = 1; #1;
    checks++; if (pred_take_D !== 1'b0) begin errors++; $display("FAIL stall_after_nt_pred got %0b expected 0", pred_take_D); end
    set_idle();
  endtask

  task automatic test_repair();
    do_reset();
    issue_resolve(32'(32'h100 << 2), 1);  // pht[0x100]=10, ghr=1
    issue_resolve(32'(32'h300 << 2), 0);  // ghr=2
    issue_resolve(32'(32'h380 << 2), 1);  // ghr=5
    pc_D = 32'(32'h200 << 2); branch_D = 1; #1;
    checks++; if (pred_take_D !== 1'b0) begin errors++; $display("FAIL repair_e_pred got %0b expected 0", pred_take_D); end
    tick();
    // Wrong-path Decode branch hits pht[0x100] through ghr 0x0A.
    pc_D = 32'(32'h10A << 2); branch_D = 1; actual_take_E = 1; flush_E = 1; #1;
    checks++; if (pred_take_D !== 1'b1) begin errors++; $display("FAIL repair_wrongpath_pred got %0b expected 1", pred_take_D); end
    checks++; if (mispredict_E !== 1'b1) begin errors++; $display("FAIL repair_mis got %0b expected 1", mispredict_E); end
    tick();
    flush_E = 0; actual_take_E = 0;
    pc_D = 32'(32'h10B << 2); branch_D = 1; #1;
    checks++; if (pred_take_D !== 1'b1) begin errors++; $display("FAIL repair_ghr_pred got %0b expected 1", pred_take_D); end
    checks++; if (branch_valid_E !== 1'b0) begin errors++; $display("FAIL repair_flush_valid got %0b expected 0", branch_valid_E); end
    set_idle();
  endtask

  task automatic test_flush();
    do_reset();
    pc_D = pc_for(32'h55); branch_D = 1; flush_E = 1; #1;
    tick();
    flush_E = 0; branch_D = 0; actual_take_E = 1; #1;
    checks++; if (branch_valid_E !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b expected 0", branch_valid_E); end
    checks++; if (mispredict_E !== 1'b0) begin errors++; $display("FAIL flush_mis got %0b expected 0", mispredict_E); end
    tick();
    actual_take_E = 0;
    pc_D = pc_for(32'h55); branch_D = 1; #1;
    checks++; if (pred_take_D !== 1'b0) begin errors++; $display("FAIL flush_no_train got %0b expected 0", pred_take_D); end
    set_idle();
  endtask

  task automatic test_reset_midop();
    do_reset();
    issue_resolve(pc_for(7), 1);
    issue_resolve(pc_for(7), 1);
    pc_D = pc_for(7); branch_D = 1; #1;
    checks++; if (pred_take_D !== 1'b1) begin errors++; $display("FAIL midrst_pre_pred got %0b expected 1", pred_take_D); end
    tick();
    actual_take_E = 0; #1;
    checks++; if (mispredict_E !== 1'b1) begin errors++; $display("FAIL midrst_pre_mis got %0b expected 1", mispredict_E); end
    #1;
    resetn = 0;
    model_reset();
    #1;
    checks++; if (pred_take_E !== 1'b0) begin errors++; $display("FAIL midrst_pred_E got %0b expected 0", pred_take_E); end
    checks++; if (branch_valid_E !== 1'b0) begin errors++; $display("FAIL midrst_valid_E got %0b expected 0", branch_valid_E); end
    checks++; if (mispredict_E !== 1'b0) begin errors++; $display("FAIL midrst_mis got %0b expected 0", mispredict_E); end
    checks++; if (pred_take_D !== 1'b0) begin errors++; $display("FAIL midrst_pred_D got %0b expected 0", pred_take_D); end
    @(negedge clk);
    set_idle();
    resetn = 1;
    tick();
    pc_D = 32'(7 << 2); branch_D = 1; #1;
    checks++; if (pred_take_D !== 1'b0) begin errors++; $display("FAIL midrst_pht_cleared got %0b expected 0", pred_take_D); end
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      pc_D          = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      branch_D      = ($urandom_range(0, 9) < 6);
      stall_D       = ($urandom_range(0, 9) < 2);
      stall_E       = ($urandom_range(0, 9) < 2);
      flush_E       = ($urandom_range(0, 9) < 1);
      actual_take_E = ($urandom_range(0, 9) < 6);
      #1;
      checks++; if (pred_take_D !== exp_predD()) begin errors++; $display("FAIL rnd_pred_D[%0d] got %0b expected %0b", n, pred_take_D, exp_predD()); end
      checks++; if (pred_take_E !== m_pE) begin errors++; $display("FAIL rnd_pred_E[%0d] got %0b expected %0b", n, pred_take_E, m_pE); end
      checks++; if (branch_valid_E !== m_vE) begin errors++; $display("FAIL rnd_valid_E[%0d] got %0b expected %0b", n, branch_valid_E, m_vE); end
      checks++; if (mispredict_E !== exp_mis()) begin errors++; $display("FAIL rnd_mis[%0d] got %0b expected %0b", n, mispredict_E, exp_mis()); end
      tick();
    end
    set_idle();
  endtask

  initial begin
    resetn = 0;
    set_idle();
    model_reset();
    test_reset();
    test_saturation();
    test_stall_e();
    test_repair();
    test_flush();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Gshare direction predictor at the front of the branch-resolution path.
- Produces the taken/not-taken prediction for conditional branches in Decode.
- Carries that prediction and its table index to Execute, where the branch outcome checker compares it with the resolved direction.
- Consumes the resolved outcome to train the pattern history table and repair the speculative global history on a mispredict.

Parameters:
- INDEX_W, 10, log2 of pattern-history-table entries; PC bits [INDEX_W+1:2] form the index.
- GHR_W, 8, global history length; must satisfy 1 <= GHR_W <= INDEX_W.

Ports:
- clk  input  1  core clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- pc_D  input  32  PC of the instruction in Decode.
- branch_D  input  1  Decode instruction is a conditional branch (beq/bne/blez/bgtz/bgez/bltz).
- stall_D  input  1  Decode held this cycle.
- stall_E  input  1  Execute held this cycle.
- flush_E  input  1  Execute register cleared at this edge.
- actual_take_E  input  1  resolved direction from the Execute branch check.
- pred_take_D  output  1  prediction for the Decode instruction.
- pred_take_E  output  1  prediction carried to Execute, fed to the branch check.
- branch_valid_E  output  1  Execute holds a predicted conditional branch.
- mispredict_E  output  1  branch_valid_E & (actual_take_E != pred_take_E).

Behaviour:
- Reset (resetn low, asynchronous): all PHT counters = 2'b01 (weakly not-taken); ghr = 0; E-stage register (valid, index, ghr snapshot, pred) = 0. Consequences: pred_take_D = 0, pred_take_E = 0, branch_valid_E = 0, mispredict_E = 0.
- Index: idx_D = pc_D[INDEX_W+1:2] XOR {zero-extend ghr to INDEX_W}.
- Prediction (combinational, zero latency): pred_take_D = branch_D & pht[idx_D][1].
- PHT read: read-before-write. A same-cycle update to idx_D does not affect pred_take_D.
- Speculative history: on an edge where branch_D & ~stall_D & ~(mispredict_E & ~stall_E), ghr <= {ghr[GHR_W-2:0], pred_take_D}. For GHR_W = 1, ghr <= pred_take_D.
- D-to-E register, priority order:
  - flush_E: valid_E <= 0.
  - else if ~stall_E: valid_E <= branch_D & ~stall_D; idx_E <= idx_D; ghr_snap_E <= ghr (pre-shift); pred_E <= pred_take_D.
  - else: hold.
- Outputs from the register: branch_valid_E = valid_E; pred_take_E = pred_E.
- Training: one update per branch, only on an edge with valid_E & ~stall_E.
  - pht[idx_E] incremented if actual_take_E, decremented otherwise.
  - Counter saturates at 2'b11 and 2'b00; no wrap.
  - A stalled branch is never trained twice.
- Repair: on the training edge, if mispredict_E, ghr <= {ghr_snap_E[GHR_W-2:0], actual_take_E}.
- Repair priority: repair overrides any same-cycle speculative shift from Decode, because the Decode instruction is wrong-path and will be flushed.
- flush_E and a valid E branch on the same edge: if ~stall_E, the E branch is trained and repaired on that edge, then valid_E clears. flush_E only removes the entry for the next cycle.
- mispredict_E is combinational and asserts even while stall_E is high. The hazard unit must ignore it until ~stall_E.
- Reset mid-operation: all state returns to reset values immediately; no partial update completes.

Decomposition:
- Shared define file gets counter encodings: `BP_SNT 2'b00, `BP_WNT 2'b01, `BP_WT 2'b10, `BP_ST 2'b11.
- Shared define file also gets the reset counter value `BP_INIT = `BP_WNT.
- One sub-module, bp_pht: 2^INDEX_W × 2-bit array, one async read port, one synchronous saturating-update write port, async active-low reset to `BP_INIT.
- The top level holds ghr, the index hash, the D-to-E register and the control logic.

Test Plan:
- After reset, pc_D=0x0040_0010, branch_D=1 -> pred_take_D=0; one edge later branch_valid_E=1, pred_take_E=0. With actual_take_E=1 -> mispredict_E=1, pht[4]=2'b10, ghr=0x01.
- Same branch PC resolved taken 3 times with ghr forced equal each time -> counter goes 01→10→11→11 (saturates); then actual_take_E=0 -> 2'b10, prediction still taken.
- stall_E=1 for 3 cycles with a valid taken branch in E -> counter changes exactly once, on the first edge with stall_E=0.
- Mispredict in E (pred 0, actual 1, ghr_snap 0x05) while branch_D=1 predicts taken in the same cycle -> ghr=0x0B, not the shifted speculative value.
- flush_E=1 with branch_D=1, stall_E=0 -> next cycle branch_valid_E=0, mispredict_E=0, and no PHT update occurs on the following edge.
- resetn pulsed low while valid_E=1 and pht[7]=2'b11 -> outputs 0 immediately (asynchronous), pht[7]=2'b01, ghr=0.
